segment_display_arbiter: RTL and testbench

//   Shares the 8-digit seven-segment display between two requesters:
//   A, the low-priority status/timer source, and B, the high-priority alarm source.

---
 rtl/segment_display_arbiter.sv | 152 +++++++++++++++
 tb/tb_segment_display_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/segment_display_arbiter.sv
// segment_display_arbiter: shares the 8-digit seven-segment display between a
// low-priority source A and a high-priority alarm source B. A grant is held for
// at least HOLD_TICKS cycles, B's pattern can blink, and a free-running
// scan_tick enable slows the downstream digit scanning.
module segment_display_arbiter #(
  parameter int HOLD_TICKS = 500,
  parameter int BLINK_DIV  = 250000,
  parameter int SCAN_DIV   = 5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic [63:0] data_a,
  input  logic        req_b,
  input  logic [63:0] data_b,
  input  logic        blink_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [7:0]  seg0,
  output logic [7:0]  seg1,
  output logic [7:0]  seg2,
  output logic [7:0]  seg3,
  output logic [7:0]  seg4,
  output logic [7:0]  seg5,
  output logic [7:0]  seg6,
  output logic [7:0]  seg7,
  output logic        scan_tick
);

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_on_q, phase_on_d;
  logic [63:0]   pat_q, pat_d;
  logic [63:0]   seg_q, seg_d;
  logic          gnt_a_q, gnt_a_d;
  logic          gnt_b_q, gnt_b_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic          scan_tick_q, scan_tick_d;
  logic          hold_done;

  // Next owner: B preempts A at once, A never preempts B, release waits for hold.
  always_comb begin
    state_d   = state_q;
    hold_done = (hold_cnt_q == HOLD_MAX);
    unique case (state_q)
      IDLE: begin
        if (req_b)      state_d = OWN_B;
        else if (req_a) state_d = OWN_A;
      end
      OWN_A: begin
        if (req_b)                    state_d = OWN_B;
        else if (!req_a && hold_done) state_d = IDLE;
      end
      OWN_B: begin
        if (!req_b && hold_done) state_d = req_a ? OWN_A : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold/blink/scan counters and the registered display outputs.
  always_comb begin
    hold_cnt_d  = '0;
    blink_cnt_d = '0;
    phase_on_d  = 1'b1;
    pat_d       = pat_q;
    scan_cnt_d  = scan_cnt_q + SW'(1);
    scan_tick_d = 1'b0;

    // Hold count restarts on every change of owner and saturates at the release point.
    if (state_d != IDLE && state_d == state_q)
      hold_cnt_d = hold_done ? hold_cnt_q : hold_cnt_q + HW'(1);

    // Blink only advances while B keeps the display and asks for blinking.
    if (state_d == OWN_B && state_q == OWN_B && blink_b) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        phase_on_d  = ~phase_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        phase_on_d  = phase_on_q;
      end
    end

    // Pattern follows the owner's data while it requests; frozen during the hold tail.
    unique case (state_d)
      IDLE:    pat_d = '0;
      OWN_A:   if (req_a) pat_d = data_a;
      OWN_B:   if (req_b) pat_d = data_b;
      default: pat_d = '0;
    endcase

    seg_d   = phase_on_d ? pat_d : 64'h0;
    gnt_a_d = (state_d == OWN_A);
    gnt_b_d = (state_d == OWN_B);

    if (scan_cnt_q == SCAN_MAX) begin
      scan_cnt_d  = '0;
      scan_tick_d = 1'b1;
    end
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_on_q  <= 1'b1;
      pat_q       <= '0;
      seg_q       <= '0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      scan_cnt_q  <= '0;
      scan_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_on_q  <= phase_on_d;
      pat_q       <= pat_d;
      seg_q       <= seg_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      scan_cnt_q  <= scan_cnt_d;
      scan_tick_q <= scan_tick_d;
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign scan_tick = scan_tick_q;
  assign seg0      = seg_q[7:0];
  assign seg1      = seg_q[15:8];
  assign seg2      = seg_q[23:16];
  assign seg3      = seg_q[31:24];
  assign seg4      = seg_q[39:32];
  assign seg5      = seg_q[47:40];
  assign seg6      = seg_q[55:48];
  assign seg7      = seg_q[63:56];

endmodule

// File: tb/tb_segment_display_arbiter.sv
// Bench for segment_display_arbiter: vector table for grant/hold sequences,
// hand-written blink, scan and async-reset sequences, then random traffic
// checked against a behavioural model.
module tb_segment_display_arbiter;

  localparam int HOLD  = 4;
  localparam int BLINK = 3;
  localparam int SCAN  = 5;
  localparam logic [63:0] DA = 64'h0102030405060708;
  localparam logic [63:0] DB = 64'hA1A2A3A4A5A6A7A8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b, blink_b;
  logic [63:0] data_a, data_b;
  logic        gnt_a, gnt_b, scan_tick;
  logic [7:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
  logic [63:0] segs;

  assign segs = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

  segment_display_arbiter #(
    .HOLD_TICKS(HOLD), .BLINK_DIV(BLINK), .SCAN_DIV(SCAN)
  ) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
    .blink_b(blink_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .seg4(seg4), .seg5(seg5), .seg6(seg6), .seg7(seg7),
    .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        ra;
    logic        rb;
    logic        ga;
    logic        gb;
    logic [63:0] segs;
  } vec_t;

  function automatic vec_t mk(input logic ra, input logic rb, input logic ga,
                              input logic gb, input logic [63:0] s);
    vec_t v;
    v.ra = ra; v.rb = rb; v.ga = ga; v.gb = gb; v.segs = s;
    return v;
  endfunction

  vec_t tbl [0:24];

  // Behavioural model: owner 0=none, 1=A, 2=B; age = edges since grant began.
  int          m_owner, m_age, m_run, m_n;
  logic [63:0] m_pat, m_segs;
  logic        m_tick;

  task model_init();
    m_owner = 0; m_age = 0; m_run = 0; m_n = 0;
    m_pat = '0; m_segs = '0; m_tick = 1'b0;
  endtask

  task model_step();
    int nw;
    bit released;
    m_n++;
    m_tick = (m_n % SCAN == 0);
    released = (m_age >= HOLD - 1);
    nw = m_owner;
    if (m_owner == 0)      nw = req_b ? 2 : (req_a ? 1 : 0);
    else if (m_owner == 1) nw = req_b ? 2 : ((!req_a && released) ? 0 : 1);
    else if (!req_b && released) nw = req_a ? 1 : 0;
    if (nw == 2 && m_owner == 2 && blink_b) m_run++;
    else m_run = 0;
    m_age = (nw != m_owner) ? 0 : m_age + 1;
    m_owner = nw;
    if (nw == 0)                m_pat = '0;
    else if (nw == 1 && req_a)  m_pat = data_a;
    else if (nw == 2 && req_b)  m_pat = data_b;
    m_segs = (nw == 2 && ((m_run / BLINK) % 2 == 1)) ? 64'h0 : m_pat;
  endtask

  task run_cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("model_gnt_a", {65'h0, gnt_a}, {65'h0, (m_owner == 1)});
    chk("model_gnt_b", {65'h0, gnt_b}, {65'h0, (m_owner == 2)});
    chk("model_segs", {2'b0, segs}, {2'b0, m_segs});
    chk("model_scan_tick", {65'h0, scan_tick}, {65'h0, m_tick});
  endtask

  task rand_inputs();
    if ($urandom_range(5) == 0) req_a = ~req_a;
    if ($urandom_range(7) == 0) req_b = ~req_b;
    if ($urandom_range(9) == 0) blink_b = ~blink_b;
    data_a = {$urandom, $urandom};
    data_b = {$urandom, $urandom};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; blink_b = 1'b0;
    data_a = DA; data_b = DB;

    // Grant/hold vectors: single-cycle A pulse, simultaneous requests, B preempting A.
    tbl[0] = mk(1, 0, 1, 0, DA);
    tbl[1] = mk(0, 0, 1, 0, DA);
    tbl[2] = mk(0, 0, 1, 0, DA);
    tbl[3] = mk(0, 0, 1, 0, DA);
    tbl[4] = mk(0, 0, 0, 0, 64'h0);
    tbl[5] = mk(0, 0, 0, 0, 64'h0);
    tbl[6] = mk(1, 1, 0, 1, DB);
    tbl[7] = mk(1, 1, 0, 1, DB);
    tbl[8] = mk(1, 0, 0, 1, DB);
    tbl[9] = mk(1, 0, 0, 1, DB);
    for (int i = 10; i <= 19; i++) tbl[i] = mk(1, 0, 1, 0, DA);
    tbl[20] = mk(1, 1, 0, 1, DB);
    tbl[21] = mk(0, 0, 0, 1, DB);
    tbl[22] = mk(0, 0, 0, 1, DB);
    tbl[23] = mk(0, 0, 0, 1, DB);
    tbl[24] = mk(0, 0, 0, 0, 64'h0);

    #1;
    chk("reset_gnt", {64'h0, gnt_a, gnt_b}, 66'h0);
    chk("reset_segs", {2'b0, segs}, 66'h0);
    chk("reset_scan_tick", {65'h0, scan_tick}, 66'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i <= 24; i++) begin
      req_a = tbl[i].ra;
      req_b = tbl[i].rb;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d", i), {gnt_a, gnt_b, segs}, {tbl[i].ga, tbl[i].gb, tbl[i].segs});
    end

    // Blink: 3 cycles ON, 3 OFF; dropping blink_b in an OFF phase restores the pattern.
    data_b = {8{8'hFF}};
    req_b = 1'b1;
    blink_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("blink%0d", i), {1'b0, gnt_b, segs},
          {1'b0, 1'b1, (((i / 3) % 2) == 1) ? 64'h0 : {8{8'hFF}}});
    end
    blink_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("blink_off_restore", {2'b0, segs}, {2'b0, {8{8'hFF}}});

    // Asynchronous reset while B owns the display, checked before the next edge.
    #1 reset = 1'b1;
    #1;
    chk("async_rst_gnt", {64'h0, gnt_a, gnt_b}, 66'h0);
    chk("async_rst_segs", {2'b0, segs}, 66'h0);
    req_a = 1'b0; req_b = 1'b0; blink_b = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_init();

    // Scan tick over 20 cycles after reset under random request traffic.
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      run_cycle();
      if (scan_tick) ticks++;
    end
    chk("scan_tick_count", 66'(ticks), 66'd4);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
